jstk_spi_responder: RTL and testbench



---
 rtl/jstk_pkg.sv | 24 ++
 rtl/jstk_spi_responder_if.sv | 10 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/jstk_spi_responder.sv | 152 +++++++++++++++
 tb/tb_jstk_spi_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jstk_pkg.sv
// Shared PmodJSTK definitions: command prefix, frame size, FSM states and the
// x/y/btn frame packing used by both the responder and master-side checks.
package jstk_pkg;

  localparam int          JSTK_FRAME_BYTES = 5;
  localparam int          JSTK_FRAME_BITS  = 8 * JSTK_FRAME_BYTES;
  localparam logic [5:0]  JSTK_CMD_PREFIX  = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } jstk_state_e;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI wire bundle between our SPI master and the joystick responder.
interface jstk_spi_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sck, output cs, output mosi, input miso);
  modport slave  (input sck, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI control line, with one
// history flop to produce single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK: serves the X/Y/button frame on miso
// and decodes the LED command byte from mosi, oversampled on clk50M.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BYTES = JSTK_FRAME_BYTES,
  parameter logic [5:0] CMD_PREFIX  = JSTK_CMD_PREFIX
) (
  input  logic                  clk50M,
  input  logic                  rst,
  jstk_spi_responder_if.slave   spi,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [2:0]            btn,
  output logic                  led1,
  output logic                  led2,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int FRAME_BITS = 8 * FRAME_BYTES;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int WARM_W     = $clog2(SYNC_STAGES + 2);
  localparam int TX_BITS    = JSTK_FRAME_BITS;

  logic sck_rise_raw, sck_fall_raw, cs_rise_raw, cs_fall_raw;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk (clk50M), .rst (rst), .d (spi.sck),
    .rise(sck_rise_raw), .fall(sck_fall_raw)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk (clk50M), .rst (rst), .d (spi.cs),
    .rise(cs_rise_raw), .fall(cs_fall_raw)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic                   warm_done;
  jstk_state_e            state_q, state_d;
  logic [TX_BITS-1:0]     tx_q, tx_d;
  logic [FRAME_BITS-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   miso_q, miso_d;
  logic                   led1_q, led1_d, led2_q, led2_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [7:0]             rx_byte0;

  // Edges are masked until the synchronisers hold real pin values, so a frame
  // already running when rst drops never looks like a fresh cs fall.
  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES + 1));
  assign sck_rise  = sck_rise_raw & warm_done;
  assign sck_fall  = sck_fall_raw & warm_done;
  assign cs_rise   = cs_rise_raw  & warm_done;
  assign cs_fall   = cs_fall_raw  & warm_done;
  assign rx_byte0  = rx_q[FRAME_BITS-1 -: 8];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    warm_d      = warm_done ? warm_q : warm_q + WARM_W'(1);
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    led1_d      = led1_q;
    led2_d      = led2_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_d    = jstk_pack(x, y, btn);
          miso_d  = tx_d[TX_BITS-1];
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (sck_rise) begin
            rx_d  = {rx_q[FRAME_BITS-2:0], mosi_sync_q[SYNC_STAGES-1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(FRAME_BITS)) state_d = ST_HOLD;
          end
          if (sck_fall) begin
            tx_d   = {tx_q[TX_BITS-2:0], 1'b0};
            miso_d = tx_d[TX_BITS-1];
          end
        end
      end
      ST_HOLD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          done_d = 1'b1;
          if (rx_byte0[7:2] == CMD_PREFIX) begin
            led2_d = rx_byte0[1];
            led1_d = rx_byte0[0];
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      mosi_sync_q <= '0;
      warm_q      <= '0;
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      led1_q      <= 1'b0;
      led2_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      warm_q      <= warm_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      led1_q      <= led1_d;
      led2_q      <= led2_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign spi.miso   = miso_q;
  assign led1       = led1_q;
  assign led2       = led2_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: expected miso bytes and frame pulses
// are queued per transaction and matched by independent monitor processes.
module tb_jstk_spi_responder;

  logic       clk50M = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic [2:0] btn;
  logic       led1, led2, frame_done, frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_bytes[$];
  logic [3:0] exp_pulse[$];  // {frame_done, frame_err, led2, led1}

  jstk_spi_responder_if spi ();

  jstk_spi_responder dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .spi       (spi),
    .x         (x),
    .y         (y),
    .btn       (btn),
    .led1      (led1),
    .led2      (led2),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #10 clk50M = ~clk50M;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Byte monitor: master samples miso on each sck rise while cs is low.
  int         mon_bits = 0;
  logic [7:0] mon_shift = 8'h00;
  always @(posedge spi.sck or posedge spi.cs) begin
    if (spi.cs) begin
      mon_bits = 0;
    end else begin
      mon_shift = {mon_shift[6:0], spi.miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_byte: got %0h, expected no byte", mon_shift);
        end else begin
          check("miso_byte", {24'h0, mon_shift}, {24'h0, exp_bytes.pop_front()});
        end
      end
    end
  end

  // Pulse monitor: every frame_done/frame_err cycle must match a queued entry.
  always @(negedge clk50M) begin
    if (frame_done === 1'b1 || frame_err === 1'b1) begin
      if (exp_pulse.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_pulse: got done/err/led2/led1=%b, expected no pulse",
                 {frame_done, frame_err, led2, led1});
      end else begin
        check("frame_pulse", {28'h0, frame_done, frame_err, led2, led1},
              {28'h0, exp_pulse.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // mo holds up to six command bytes, MSB first in mo[47:40].
  task automatic spi_xfer(input logic [47:0] mo, input int nbits,
                          input int xchg_at, input int rst_at);
    spi.cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == xchg_at) x = 10'h000;
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check("rst_led1", {31'h0, led1}, 32'h0);
        check("rst_led2", {31'h0, led2}, 32'h0);
        check("rst_miso", {31'h0, spi.miso}, 32'h0);
        wait_clk(10);
      end
      spi.mosi = mo[47-i];
      wait_clk(6);
      spi.sck = 1'b1;
      wait_clk(6);
      spi.sck = 1'b0;
    end
    wait_clk(6);
    spi.cs = 1'b1;
    wait_clk(20);
  endtask

  task automatic push_bytes5(input logic [39:0] b);
    for (int i = 0; i < 5; i++) exp_bytes.push_back(b[39-8*i -: 8]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spi.sck = 1'b0;
    spi.cs = 1'b1;
    spi.mosi = 1'b0;
    x = 10'h2A5;
    y = 10'h13C;
    btn = 3'b101;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("reset_miso", {31'h0, spi.miso}, 32'h0);
    check("reset_led1", {31'h0, led1}, 32'h0);
    check("reset_led2", {31'h0, led2}, 32'h0);
    check("reset_done", {31'h0, frame_done}, 32'h0);
    check("reset_err", {31'h0, frame_err}, 32'h0);

    // Good command 0x83 -> both LEDs on.
    push_bytes5(40'hA5_02_3C_01_05);
    exp_pulse.push_back(4'b1011);
    spi_xfer({8'h83, 40'h0}, 40, -1, -1);

    // Bad prefix 0x43 -> done+err together, LEDs held.
    push_bytes5(40'hA5_02_3C_01_05);
    exp_pulse.push_back(4'b1111);
    spi_xfer({8'h43, 40'h0}, 40, -1, -1);

    // Abort after 17 bits -> err only, LEDs held, miso back to 0.
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h02);
    exp_pulse.push_back(4'b0111);
    spi_xfer({8'h81, 40'h0}, 17, -1, -1);
    check("abort_miso", {31'h0, spi.miso}, 32'h0);
    check("abort_leds", {30'h0, led2, led1}, 32'h3);

    push_bytes5(40'hA5_02_3C_01_05);
    exp_pulse.push_back(4'b1001);
    spi_xfer({8'h81, 40'h0}, 40, -1, -1);

    // Snapshot: x changes to 0 after byte0 but the frame keeps 0x3FF.
    x = 10'h3FF;
    push_bytes5(40'hFF_03_3C_01_05);
    exp_pulse.push_back(4'b1000);
    spi_xfer({8'h80, 40'h0}, 40, 8, -1);

    // Overrun: 48 clocks, trailing byte reads zero.
    push_bytes5(40'h00_00_3C_01_05);
    exp_bytes.push_back(8'h00);
    exp_pulse.push_back(4'b1010);
    spi_xfer({8'h82, 40'h0}, 48, -1, -1);

    // rst after byte2: rest of that frame is ignored, no pulse expected.
    x = 10'h2A5;
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h3C);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h00);
    spi_xfer({8'h83, 40'h0}, 40, -1, 24);
    check("post_rst_leds", {30'h0, led2, led1}, 32'h0);

    push_bytes5(40'hA5_02_3C_01_05);
    exp_pulse.push_back(4'b1001);
    spi_xfer({8'h81, 40'h0}, 40, -1, -1);

    wait_clk(20);
    check("bytes_left", exp_bytes.size(), 32'h0);
    check("pulses_left", exp_pulse.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
